prog_sequencer: RTL and testbench

- Clocked run controller that sequences the single-issue 9-bit core through fetch, execute, memory-wait and halt.
- Owns the registered mode register S. The decoder reads S as an input.
- Gates the decoder's write, memory and LFSR strobes so each takes effect exactly once per instruction.
- Drives the PC control lines and the top-level Req/Ack start/done handshake.

---
 rtl/prog_sequencer_pkg.sv | 24 ++
 rtl/prog_sequencer_if.sv | 54 +++++
 rtl/prog_sequencer.sv | 157 +++++++++++++++
 tb/tb_prog_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the 9-bit core run controller: sequencer states,
// the two opcodes the sequencer decodes itself, and field widths.
// Optional single-step build: define SEQ_SINGLE_STEP_EN to add the PAUSE state.
package prog_sequencer_pkg;

  localparam int MODE_W  = 2;
  localparam int INSTR_W = 9;

  localparam logic [2:0] OP_SETMODE = 3'b110;
  localparam logic [2:0] OP_HALT    = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    HALT  = 3'd4
`ifdef SEQ_SINGLE_STEP_EN
    ,
    PAUSE = 3'd5
`endif
  } seq_state_t;

endpackage

// File: rtl/prog_sequencer_if.sv
// Bundle of everything the sequencer exchanges with the rest of the core:
// start/done handshake, instruction and decoder strobes in, gated strobes,
// PC controls, mode register and retire counter out.
// With SEQ_SINGLE_STEP_EN defined the bundle also carries the Step input.
interface prog_sequencer_if #(parameter int CNT_W = 16);
  import prog_sequencer_pkg::*;

  logic               Req;
  logic               Ack;
  logic               Busy;
  logic [INSTR_W-1:0] Instruction;
  logic [MODE_W-1:0]  Mode;
  logic               DecRegWrite;
  logic               DecMemWrite;
  logic               DecMemRead;
  logic               DecNextLFSR;
  logic               DecBranchEn;
  logic               BranchTaken;
  logic               MemReady;
  logic               PcReset;
  logic               PcInc;
  logic               PcBranch;
  logic               RegWriteEn;
  logic               MemWriteEn;
  logic               MemReadEn;
  logic               LfsrStep;
  logic [CNT_W-1:0]   InstrCount;
`ifdef SEQ_SINGLE_STEP_EN
  logic               Step;
`endif

  // Core / testbench side: drives requests and decoder results.
  modport master (
`ifdef SEQ_SINGLE_STEP_EN
    output Step,
`endif
    output Req, Instruction, DecRegWrite, DecMemWrite, DecMemRead,
    output DecNextLFSR, DecBranchEn, BranchTaken, MemReady,
    input  Ack, Busy, Mode, PcReset, PcInc, PcBranch,
    input  RegWriteEn, MemWriteEn, MemReadEn, LfsrStep, InstrCount
  );

  // Sequencer side.
  modport slave (
`ifdef SEQ_SINGLE_STEP_EN
    input  Step,
`endif
    input  Req, Instruction, DecRegWrite, DecMemWrite, DecMemRead,
    input  DecNextLFSR, DecBranchEn, BranchTaken, MemReady,
    output Ack, Busy, Mode, PcReset, PcInc, PcBranch,
    output RegWriteEn, MemWriteEn, MemReadEn, LfsrStep, InstrCount
  );

endinterface

// File: rtl/prog_sequencer.sv
// Run controller for the single-issue 9-bit core. Walks each instruction
// through FETCH/EXEC (and MEM for loads/stores), gates the decoder strobes so
// each fires once per instruction, owns the mode register and counts retired
// instructions with a saturating counter.
// Optional: SEQ_SINGLE_STEP_EN parks every retire in PAUSE until Step=1.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int                CNT_W      = 16,
  parameter logic [MODE_W-1:0] START_MODE = 2'b00
) (
  input  logic               Clk,
  input  logic               Reset_n,
  prog_sequencer_if.slave    bus
);

`ifdef SEQ_SINGLE_STEP_EN
  localparam seq_state_t RETIRE_TO = PAUSE;
`else
  localparam seq_state_t RETIRE_TO = FETCH;
`endif

  seq_state_t        state, next_state;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  count_inc;
  logic              mem_write_q, mem_write_d;
  logic [2:0]        opcode;

  logic pc_reset, pc_inc, pc_branch;
  logic reg_write_en, mem_write_en, mem_read_en, lfsr_step;

  // Operand bits the sequencer never looks at (the ALU/decoder use them).
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.Instruction[5:2];

  assign opcode    = bus.Instruction[8:6];
  assign count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);

  // State, mode, retire counter and pending-access kind; reset aborts any access.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      mode_q      <= START_MODE;
      count_q     <= '0;
      mem_write_q <= 1'b0;
    end else begin
      state       <= next_state;
      mode_q      <= mode_d;
      count_q     <= count_d;
      mem_write_q <= mem_write_d;
    end
  end

  // Next-state decode and the once-per-instruction strobe gating.
  always_comb begin
    next_state   = state;
    mode_d       = mode_q;
    count_d      = count_q;
    mem_write_d  = mem_write_q;
    pc_reset     = 1'b0;
    pc_inc       = 1'b0;
    pc_branch    = 1'b0;
    reg_write_en = 1'b0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    lfsr_step    = 1'b0;

    case (state)
      IDLE: begin
        // PcReset is Mealy on Req, so mask it while reset is held.
        if (bus.Req && Reset_n) begin
          pc_reset   = 1'b1;
          mode_d     = START_MODE;
          count_d    = '0;
          next_state = FETCH;
        end
      end

      FETCH: begin
        next_state = EXEC;
      end

      EXEC: begin
        if (opcode == OP_HALT) begin
          next_state = HALT;
        end else if (opcode == OP_SETMODE) begin
          mode_d     = bus.Instruction[MODE_W-1:0];
          pc_inc     = 1'b1;
          count_d    = count_inc;
          next_state = RETIRE_TO;
        end else if (bus.DecMemWrite || bus.DecMemRead) begin
          // A store wins if the decoder ever raises both.
          mem_write_en = bus.DecMemWrite;
          mem_read_en  = !bus.DecMemWrite;
          mem_write_d  = bus.DecMemWrite;
          next_state   = MEM;
        end else begin
          reg_write_en = bus.DecRegWrite;
          lfsr_step    = bus.DecNextLFSR;
          if (bus.DecBranchEn && bus.BranchTaken) begin
            pc_branch = 1'b1;
          end else begin
            pc_inc = 1'b1;
          end
          count_d    = count_inc;
          next_state = RETIRE_TO;
        end
      end

      MEM: begin
        mem_write_en = mem_write_q;
        mem_read_en  = !mem_write_q;
        if (bus.MemReady) begin
          reg_write_en = bus.DecRegWrite && !mem_write_q;
          pc_inc       = 1'b1;
          count_d      = count_inc;
          next_state   = RETIRE_TO;
        end
      end

      HALT: begin
        if (!bus.Req) begin
          next_state = IDLE;
        end
      end

`ifdef SEQ_SINGLE_STEP_EN
      PAUSE: begin
        if (bus.Step) begin
          next_state = FETCH;
        end
      end
`endif

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs: Ack/Busy are Moore on state, strobes come from the decode above.
  always_comb begin
    bus.Ack        = (state == HALT);
    bus.Busy       = (state != IDLE) && (state != HALT);
    bus.Mode       = mode_q;
    bus.InstrCount = count_q;
    bus.PcReset    = pc_reset;
    bus.PcInc      = pc_inc;
    bus.PcBranch   = pc_branch;
    bus.RegWriteEn = reg_write_en;
    bus.MemWriteEn = mem_write_en;
    bus.MemReadEn  = mem_read_en;
    bus.LfsrStep   = lfsr_step;
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: two instances (16-bit and 4-bit retire
// counters) share one stimulus stream; expectations are hand-computed.
module tb_prog_sequencer;
  import prog_sequencer_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [8:0] instr;
  logic       dec_reg_write, dec_mem_write, dec_mem_read;
  logic       dec_next_lfsr, dec_branch_en, branch_taken, mem_ready;

  int tests_run;
  int tests_failed;

  prog_sequencer_if #(.CNT_W(16)) if_main ();
  prog_sequencer_if #(.CNT_W(4))  if_small ();

  assign if_main.Req          = req;
  assign if_main.Instruction  = instr;
  assign if_main.DecRegWrite  = dec_reg_write;
  assign if_main.DecMemWrite  = dec_mem_write;
  assign if_main.DecMemRead   = dec_mem_read;
  assign if_main.DecNextLFSR  = dec_next_lfsr;
  assign if_main.DecBranchEn  = dec_branch_en;
  assign if_main.BranchTaken  = branch_taken;
  assign if_main.MemReady     = mem_ready;
  assign if_small.Req         = req;
  assign if_small.Instruction = instr;
  assign if_small.DecRegWrite = dec_reg_write;
  assign if_small.DecMemWrite = dec_mem_write;
  assign if_small.DecMemRead  = dec_mem_read;
  assign if_small.DecNextLFSR = dec_next_lfsr;
  assign if_small.DecBranchEn = dec_branch_en;
  assign if_small.BranchTaken = branch_taken;
  assign if_small.MemReady    = mem_ready;
`ifdef SEQ_SINGLE_STEP_EN
  assign if_main.Step  = 1'b1;
  assign if_small.Step = 1'b1;
`endif

  prog_sequencer #(.CNT_W(16), .START_MODE(2'b00)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (if_main)
  );

  prog_sequencer #(.CNT_W(4), .START_MODE(2'b00)) dut_small (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (if_small)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_decoder();
    dec_reg_write = 1'b0;
    dec_mem_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_next_lfsr = 1'b0;
    dec_branch_en = 1'b0;
    branch_taken  = 1'b0;
    mem_ready     = 1'b0;
  endtask

  // From IDLE: raise Req, expect the PcReset pulse, land in FETCH.
  task automatic apply_stimulus_start();
    req = 1'b1;
    #1;
    check_output("start_pcreset", if_main.PcReset, 1'b1);
    check_output("start_idle_busy", if_main.Busy, 1'b0);
    cycle();
    check_output("start_fetch_busy", if_main.Busy, 1'b1);
    check_output("start_pcreset_gone", if_main.PcReset, 1'b0);
    check_output("start_mode", if_main.Mode, 2'b00);
    check_output("start_count", if_main.InstrCount, 16'd0);
  endtask

  // From FETCH: one non-memory instruction, ends in the following FETCH.
  task automatic apply_stimulus_alu(input logic [8:0] ins, input logic rw, input logic lf,
                                    input logic ben, input logic bt);
    instr = ins;
    clear_decoder();
    #1;
    check_output("fetch_quiet", {if_main.PcInc, if_main.PcBranch, if_main.RegWriteEn, if_main.LfsrStep}, 4'b0000);
    cycle();
    dec_reg_write = rw;
    dec_next_lfsr = lf;
    dec_branch_en = ben;
    branch_taken  = bt;
    #1;
    check_output("exec_regwrite", if_main.RegWriteEn, rw);
    check_output("exec_lfsr", if_main.LfsrStep, lf);
    check_output("exec_pcbranch", if_main.PcBranch, ben & bt);
    check_output("exec_pcinc", if_main.PcInc, !(ben & bt));
    cycle();
    clear_decoder();
  endtask

  // From FETCH: halt opcode, ends in HALT.
  task automatic apply_stimulus_halt();
    instr = 9'b111_000000;
    clear_decoder();
    cycle();
    #1;
    check_output("halt_exec_pcinc", if_main.PcInc, 1'b0);
    cycle();
    check_output("halt_ack", if_main.Ack, 1'b1);
    check_output("halt_busy", if_main.Busy, 1'b0);
  endtask

  initial begin
    int rd_cnt, wr_cnt, rw_cnt, inc_cnt;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    req          = 1'b0;
    instr        = '0;
    clear_decoder();

    // Power-on reset state.
    #2;
    check_output("rst_ack", if_main.Ack, 1'b0);
    check_output("rst_busy", if_main.Busy, 1'b0);
    check_output("rst_mode", if_main.Mode, 2'b00);
    check_output("rst_count", if_main.InstrCount, 16'd0);
    check_output("rst_pcreset", if_main.PcReset, 1'b0);
    #1 rst_n = 1'b1;
    cycle();
    check_output("idle_busy", if_main.Busy, 1'b0);

    // Program 1: three ALU ops then halt.
    $display("[TB] program 1: three ALU ops");
    apply_stimulus_start();
    apply_stimulus_alu(9'b000_000001, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus_alu(9'b001_000010, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus_alu(9'b010_000011, 1'b1, 1'b1, 1'b1, 1'b0);
    apply_stimulus_halt();
    check_output("p1_count", if_main.InstrCount, 16'd3);
    cycle();
    check_output("p1_ack_held", if_main.Ack, 1'b1);
    req = 1'b0;
    #1;
    check_output("p1_ack_until_edge", if_main.Ack, 1'b1);
    cycle();
    check_output("p1_ack_drop", if_main.Ack, 1'b0);
    check_output("p1_idle_busy", if_main.Busy, 1'b0);

    // Program 2: set-mode 10, then a taken branch.
    $display("[TB] program 2: set-mode and branch");
    apply_stimulus_start();
    apply_stimulus_alu(9'b110_000010, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("p2_mode_after", if_main.Mode, 2'b10);
    apply_stimulus_alu(9'b011_000101, 1'b0, 1'b0, 1'b1, 1'b1);
    apply_stimulus_halt();
    check_output("p2_count", if_main.InstrCount, 16'd2);
    check_output("p2_mode_kept", if_main.Mode, 2'b10);
    req = 1'b0;
    cycle();

    // Program 3: load with slow memory, then a store. Mode reloads at start.
    $display("[TB] program 3: load and store");
    apply_stimulus_start();
    instr         = 9'b100_000000;
    dec_mem_read  = 1'b1;
    dec_reg_write = 1'b1;
    mem_ready     = 1'b1;
    #1;
    check_output("p3_fetch_ready_ignored", if_main.PcInc, 1'b0);
    cycle();
    rd_cnt = 0; rw_cnt = 0; inc_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      #1;
      rd_cnt  += int'(if_main.MemReadEn);
      rw_cnt  += int'(if_main.RegWriteEn);
      inc_cnt += int'(if_main.PcInc);
      if (k == 3) check_output("p3_load_rw_on_ready", if_main.RegWriteEn, 1'b1);
      cycle();
    end
    clear_decoder();
    #1;
    check_output("p3_load_read_drop", if_main.MemReadEn, 1'b0);
    check_output("p3_load_read_cycles", rd_cnt, 4);
    check_output("p3_load_rw_once", rw_cnt, 1);
    check_output("p3_load_inc_once", inc_cnt, 1);
    instr         = 9'b101_000000;
    dec_mem_write = 1'b1;
    dec_reg_write = 1'b1;
    cycle();
    wr_cnt = 0; rw_cnt = 0; inc_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k == 2);
      #1;
      wr_cnt  += int'(if_main.MemWriteEn);
      rw_cnt  += int'(if_main.RegWriteEn);
      inc_cnt += int'(if_main.PcInc);
      cycle();
    end
    clear_decoder();
    check_output("p3_store_write_cycles", wr_cnt, 3);
    check_output("p3_store_no_rw", rw_cnt, 0);
    check_output("p3_store_inc_once", inc_cnt, 1);
    apply_stimulus_halt();
    check_output("p3_count", if_main.InstrCount, 16'd2);
    req = 1'b0;
    cycle();

    // Program 4: reset while waiting in MEM.
    $display("[TB] program 4: reset mid-access");
    apply_stimulus_start();
    apply_stimulus_alu(9'b110_000001, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("p4_mode_01", if_main.Mode, 2'b01);
    instr        = 9'b100_000000;
    dec_mem_read = 1'b1;
    cycle();
    cycle();
    check_output("p4_mem_read", if_main.MemReadEn, 1'b1);
    rst_n = 1'b0;
    #1;
    check_output("p4_rst_read", if_main.MemReadEn, 1'b0);
    check_output("p4_rst_busy", if_main.Busy, 1'b0);
    check_output("p4_rst_ack", if_main.Ack, 1'b0);
    check_output("p4_rst_mode", if_main.Mode, 2'b00);
    check_output("p4_rst_count", if_main.InstrCount, 16'd0);
    check_output("p4_rst_pc", {if_main.PcReset, if_main.PcInc, if_main.PcBranch, if_main.RegWriteEn}, 4'b0000);
    req = 1'b0;
    clear_decoder();
    #1 rst_n = 1'b1;
    cycle();
    check_output("p4_idle_after", if_main.Busy, 1'b0);

    // Program 5: 17 ALU ops; Req dropped early must not stop the run.
    $display("[TB] program 5: counter saturation");
    apply_stimulus_start();
    req = 1'b0;
    for (int n = 0; n < 17; n++) begin
      apply_stimulus_alu(9'b000_000001, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    apply_stimulus_halt();
    check_output("p5_count_wide", if_main.InstrCount, 16'd17);
    check_output("p5_count_sat", if_small.InstrCount, 4'hF);
    cycle();
    check_output("p5_ack_drop", if_main.Ack, 1'b0);
    check_output("p5_sat_kept", if_small.InstrCount, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
